// File: rtl/q5_serial_neg_mc.sv
// N lock-stepped LSB-first serial channels: collect a W-bit word, then replay it passed, negated or made absolute.
// Output starts W cycles after the first input bit; input gaps never stall the output stream.
module q5_serial_neg_mc #(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic         in_sof,
   input  logic [N-1:0] in_bit,
   input  logic [1:0]   mode,
   output logic         out_valid,
   output logic         out_sof,
   output logic         out_eow,
   output logic [N-1:0] out_bit,
   output logic [N-1:0] ovf,
   output logic         err_frame
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {I_IDLE, I_COLLECT} ist_t;
   typedef enum logic {O_IDLE, O_SEND} ost_t;

   ist_t                r_ist, w_ist;
   logic [CW-1:0]       r_icnt, w_icnt;
   logic [N-1:0][W-1:0] r_iword, w_iword;
   logic [1:0]          r_imode, w_imode;
   ost_t                r_ost, w_ost;
   logic [CW-1:0]       r_ocnt, w_ocnt;
   logic [N-1:0][W-1:0] r_oword, w_oword;
   logic [1:0]          r_omode, w_omode;
   logic [N-1:0]        r_seen, w_seen;
   logic                r_err, w_err;
   logic                w_load;
   logic [N-1:0]        w_cur;
   logic [N-1:0]        w_neg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ist   <= I_IDLE;
         r_icnt  <= '0;
         r_iword <= '0;
         r_imode <= '0;
         r_ost   <= O_IDLE;
         r_ocnt  <= '0;
         r_oword <= '0;
         r_omode <= '0;
         r_seen  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_ist   <= w_ist;
         r_icnt  <= w_icnt;
         r_iword <= w_iword;
         r_imode <= w_imode;
         r_ost   <= w_ost;
         r_ocnt  <= w_ocnt;
         r_oword <= w_oword;
         r_omode <= w_omode;
         r_seen  <= w_seen;
         r_err   <= w_err;
      end
   end

   always_comb begin
      for (int c = 0; c < N; c++) begin
         w_cur[c] = r_oword[c][r_ocnt];
         w_neg[c] = (r_omode == 2'b01) || ((r_omode == 2'b10) && r_oword[c][W-1]);
      end
   end

   always_comb begin
      w_ist   = r_ist;
      w_icnt  = r_icnt;
      w_iword = r_iword;
      w_imode = r_imode;
      w_ost   = r_ost;
      w_ocnt  = r_ocnt;
      w_oword = r_oword;
      w_omode = r_omode;
      w_seen  = r_seen;
      w_err   = 1'b0;
      w_load  = 1'b0;

      // A fresh sof always restarts collection; a sof landing mid-word is a framing error.
      if (in_valid) begin
         if (in_sof) begin
            for (int c = 0; c < N; c++) w_iword[c][0] = in_bit[c];
            w_imode = mode;
            w_icnt  = CW'(1);
            w_ist   = I_COLLECT;
            w_err   = (r_ist == I_COLLECT);
         end else if (r_ist == I_IDLE) begin
            w_err = 1'b1;
         end else begin
            for (int c = 0; c < N; c++) w_iword[c][r_icnt] = in_bit[c];
            if (r_icnt == LAST) begin
               w_load = 1'b1;
               w_ist  = I_IDLE;
               w_icnt = '0;
            end else begin
               w_icnt = r_icnt + 1'b1;
            end
         end
      end

      if (w_load) begin
         w_ost   = O_SEND;
         w_ocnt  = '0;
         w_oword = w_iword;
         w_omode = r_imode;
         w_seen  = '0;
      end else if (r_ost == O_SEND) begin
         // Serial two's complement: bits after the first 1 get inverted.
         w_seen = r_seen | w_cur;
         if (r_ocnt == LAST) begin
            w_ost  = O_IDLE;
            w_ocnt = '0;
         end else begin
            w_ocnt = r_ocnt + 1'b1;
         end
      end
   end

   always_comb begin
      out_valid = (r_ost == O_SEND);
      out_sof   = 1'b0;
      out_eow   = 1'b0;
      out_bit   = '0;
      ovf       = '0;
      if (r_ost == O_SEND) begin
         out_sof = (r_ocnt == '0);
         out_eow = (r_ocnt == LAST);
         out_bit = w_cur ^ (w_neg & r_seen);
         for (int c = 0; c < N; c++)
            ovf[c] = (r_ocnt == LAST) && (r_omode == 2'b01 || r_omode == 2'b10)
                     && (r_oword[c] == {1'b1, {(W-1){1'b0}}});
      end
      err_frame = r_err;
   end
endmodule

// File: tb/tb_q5_serial_neg_mc.sv
// Directed bench for q5_serial_neg_mc (W=8, N=4): a negedge monitor rebuilds output words, tests compare them to hand values.
module tb_q5_serial_neg_mc;
   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_sof;
   logic [N-1:0] in_bit;
   logic [1:0]   mode;
   logic         out_valid;
   logic         out_sof;
   logic         out_eow;
   logic [N-1:0] out_bit;
   logic [N-1:0] ovf;
   logic         err_frame;

   q5_serial_neg_mc #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit), .mode(mode),
      .out_valid(out_valid), .out_sof(out_sof), .out_eow(out_eow), .out_bit(out_bit),
      .ovf(ovf), .err_frame(err_frame)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor
   logic [31:0]     q_word[$];
   logic [3:0]      q_ovf[$];
   int              q_sofc[$];
   logic [N-1:0][W-1:0] cap;
   logic [2:0]      bitpos = '0;
   logic            in_word = 1'b0;
   int              cur_sofc = 0;
   int              n_err = 0;
   int              n_idle_bad = 0;
   int              n_gap_bad = 0;
   int              n_mark_bad = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_word = 1'b0;
      end else begin
         if (err_frame) n_err++;
         if (out_valid) begin
            if (out_sof) begin
               if (in_word) n_mark_bad++;
               in_word  = 1'b1;
               bitpos   = '0;
               cur_sofc = cyc;
            end else if (!in_word) begin
               n_mark_bad++;
            end
            if (!out_eow && ovf != '0) n_mark_bad++;
            for (int c = 0; c < N; c++) cap[c][bitpos] = out_bit[c];
            if (out_eow) begin
               if (bitpos != 3'd7) n_mark_bad++;
               else begin
                  q_word.push_back(cap);
                  q_ovf.push_back(ovf);
                  q_sofc.push_back(cur_sofc);
               end
               in_word = 1'b0;
            end else begin
               if (bitpos == 3'd7) n_mark_bad++;
               bitpos = bitpos + 3'd1;
            end
         end else begin
            if (in_word) n_gap_bad++;
            if (out_sof || out_eow || out_bit != '0 || ovf != '0) n_idle_bad++;
         end
      end
   end

   task automatic drive_bit(input logic sof, input logic [N-1:0] b, input logic [1:0] m);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_sof   = sof;
      in_bit   = b;
      mode     = m;
   endtask

   // Mode is only driven meaningfully with sof; other bits carry 2'b11 to prove it is latched.
   task automatic send_word(input logic [N-1:0][W-1:0] v, input logic [1:0] m, input int gap,
                            input bit tail, output int t0);
      logic [N-1:0] b;
      t0 = 0;
      for (int k = 0; k < W; k++) begin
         for (int c = 0; c < N; c++) b[c] = v[c][k];
         drive_bit(k == 0, b, (k == 0) ? m : 2'b11);
         if (k == 0) t0 = cyc;
         if (k < W - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(posedge clk);
               #1;
               in_valid = 1'b0;
               in_sof   = 1'b1;
               in_bit   = '1;
            end
         end
      end
      if (tail) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_sof   = 1'b0;
         in_bit   = '0;
      end
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 300 && q_word.size() < n; i++) @(posedge clk);
   endtask

   task automatic expect_word(input string tag, input logic [31:0] exp_w, input logic [3:0] exp_ovf,
                              output int sofc);
      sofc = -1;
      chk_eq({tag, "_present"}, 32'(q_word.size() > 0), 32'd1);
      if (q_word.size() > 0) begin
         chk_eq({tag, "_word"}, q_word.pop_front(), exp_w);
         chk_eq({tag, "_ovf"}, 32'(q_ovf.pop_front()), 32'(exp_ovf));
         sofc = q_sofc.pop_front();
      end
   endtask

   initial begin
      int t0;
      int t1;
      int s0;
      int s1;
      int e0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_bit   = '0;
      mode     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_sof", 32'(out_sof), 32'd0);
      chk_eq("rst_eow", 32'(out_eow), 32'd0);
      chk_eq("rst_bit", 32'(out_bit), 32'd0);
      chk_eq("rst_ovf", 32'(ovf), 32'd0);
      chk_eq("rst_err", 32'(err_frame), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Negate on mixed words, including the 0x80 overflow case
      send_word({8'hFF, 8'h00, 8'h80, 8'h05}, 2'b01, 0, 1'b1, t0);
      wait_words(1);
      expect_word("neg_mix", {8'h01, 8'h00, 8'h80, 8'hFB}, 4'b0010, s0);
      chk_eq("latency", 32'(s0 - t0), 32'd8);

      // Abs / pass / reserved mode on 0xF6
      send_word({4{8'hF6}}, 2'b10, 0, 1'b1, t0);
      wait_words(1);
      expect_word("abs_f6", {4{8'h0A}}, 4'b0000, s0);
      send_word({4{8'hF6}}, 2'b00, 0, 1'b1, t0);
      wait_words(1);
      expect_word("pass_f6", {4{8'hF6}}, 4'b0000, s0);
      send_word({4{8'hF6}}, 2'b11, 0, 1'b1, t0);
      wait_words(1);
      expect_word("mode3_f6", {4{8'hF6}}, 4'b0000, s0);
      send_word({8'h80, 8'h7F, 8'h01, 8'h00}, 2'b10, 0, 1'b1, t0);
      wait_words(1);
      expect_word("abs_edge", {8'h80, 8'h7F, 8'h01, 8'h00}, 4'b1000, s0);

      // Back-to-back contiguous words, then one with 3-cycle gaps
      send_word({8'h11, 8'h22, 8'h33, 8'h44}, 2'b00, 0, 1'b0, t0);
      send_word({8'hA5, 8'h5A, 8'h0F, 8'hF0}, 2'b01, 0, 1'b0, t1);
      send_word({8'h01, 8'h02, 8'h03, 8'h04}, 2'b01, 3, 1'b1, t1);
      wait_words(3);
      expect_word("b2b_a", {8'h11, 8'h22, 8'h33, 8'h44}, 4'b0000, s0);
      expect_word("b2b_b", {8'h5B, 8'hA6, 8'hF1, 8'h10}, 4'b0000, s1);
      chk_eq("b2b_spacing", 32'(s1 - s0), 32'd8);
      expect_word("gap_c", {8'hFF, 8'hFE, 8'hFD, 8'hFC}, 4'b0000, s0);

      // sof reasserted at icnt=4
      e0 = n_err;
      drive_bit(1'b1, 4'hF, 2'b01);
      drive_bit(1'b0, 4'h0, 2'b11);
      drive_bit(1'b0, 4'hF, 2'b11);
      drive_bit(1'b0, 4'h5, 2'b11);
      send_word({8'h12, 8'h34, 8'h56, 8'h78}, 2'b00, 0, 1'b1, t0);
      wait_words(1);
      repeat (4) @(posedge clk);
      chk_eq("resof_err", 32'(n_err - e0), 32'd1);
      chk_eq("resof_cnt", 32'(q_word.size()), 32'd1);
      expect_word("resof_word", {8'h12, 8'h34, 8'h56, 8'h78}, 4'b0000, s0);

      // Reset mid-collect: silent drop
      e0 = n_err;
      drive_bit(1'b1, 4'hA, 2'b01);
      drive_bit(1'b0, 4'h5, 2'b11);
      drive_bit(1'b0, 4'hA, 2'b11);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      chk_eq("rstc_err", 32'(n_err - e0), 32'd0);
      chk_eq("rstc_out", 32'(q_word.size()), 32'd0);

      // Reset at ocnt=3 during SEND
      send_word({8'h11, 8'h22, 8'h33, 8'h44}, 2'b01, 0, 1'b1, t0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("pre_rst_vld", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_eq("rsts_valid", 32'(out_valid), 32'd0);
      chk_eq("rsts_bit", 32'(out_bit), 32'd0);
      chk_eq("rsts_eow", 32'(out_eow), 32'd0);
      chk_eq("rsts_err", 32'(err_frame), 32'd0);
      repeat (10) @(posedge clk);
      chk_eq("rsts_drop", 32'(q_word.size()), 32'd0);
      send_word({8'h9A, 8'hBC, 8'hDE, 8'hF0}, 2'b10, 0, 1'b1, t0);
      wait_words(1);
      expect_word("post_rst", {8'h66, 8'h44, 8'h22, 8'h10}, 4'b0000, s0);
      chk_eq("post_rst_lat", 32'(s0 - t0), 32'd8);

      // Stray bit while IDLE
      e0 = n_err;
      drive_bit(1'b0, 4'hF, 2'b01);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      chk_eq("stray_err", 32'(n_err - e0), 32'd1);
      chk_eq("stray_out", 32'(q_word.size()), 32'd0);

      chk_eq("idle_zero", 32'(n_idle_bad), 32'd0);
      chk_eq("valid_gap", 32'(n_gap_bad), 32'd0);
      chk_eq("markers", 32'(n_mark_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1);
   end
endmodule
